// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-enable divider.
package clk_div_pkg;

   // Run state of the divider.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Smallest divisor the load port accepts.
   localparam int unsigned DIV_MIN = 2;

   // High time of one period: ceil(d/2), one bit wider than d so the +1 never overflows.
   function automatic logic [32:0] calc_hi(input logic [31:0] d);
      return ({1'b0, d} + 33'd1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Wrapping phase counter: counts 0..div-1 while enabled, restarts at 0 on request.
module clk_div_phase
   import clk_div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [WIDTH-1:0] div,
   output logic [WIDTH-1:0] phase_next,
   output logic             wrap
);

   logic [WIDTH-1:0] phase;

   // Next phase: restart or end of period goes back to 0, otherwise advance.
   always_comb begin
      phase_next = phase + WIDTH'(1);
      if (restart || (phase == div - WIDTH'(1))) begin
         phase_next = '0;
      end
      wrap = (phase_next == '0);
   end

   // Phase register; a disabled edge parks the counter at 0 so no partial period resumes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (en) begin
         phase <= phase_next;
      end else begin
         phase <= '0;
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider with a one-deep pending divisor slot.
//
// Load handshake: div_load/div_val form a request held by the requester.
// A request is taken on an edge where div_load=1 and no response is showing.
// The response is a single-cycle pulse the cycle after the edge that took it:
// div_err if div_val < 2 (nothing changes), div_ack if div_val was stored
// in the pending slot. While the slot is full the request simply stalls.
// The requester drops div_load once it sees either pulse.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIV_DEFAULT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic             clk_out,
   output logic             clk_out_n,
   output logic             tick
);

   localparam int HW = WIDTH + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] pend_val;
   logic             pend_valid;
   logic [WIDTH-1:0] d_eff;
   logic [WIDTH:0]   hi;
   logic [WIDTH-1:0] phase_next;
   logic             wrap;
   logic             req;
   logic             apply;
   logic             accept;
   logic             reject;

   clk_div_phase #(.WIDTH(WIDTH)) u_phase (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .restart    (state_q == IDLE),
      .div        (d_reg),
      .phase_next (phase_next),
      .wrap       (wrap)
   );

   // Next state, pending-divisor application and load decisions.
   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      req     = 1'b0;
      accept  = 1'b0;
      reject  = 1'b0;
      d_eff   = d_reg;
      state_d = en ? RUN : IDLE;
      // Pending divisor lands at a period boundary in RUN, or on any edge in IDLE.
      apply = pend_valid && ((state_q == IDLE) || (en && wrap));
      if (apply) begin
         d_eff = pend_val;
      end
      // A request already answered this cycle must not be answered twice.
      req = div_load && !div_ack && !div_err;
      if (req) begin
         if (div_val < WIDTH'(DIV_MIN)) begin
            reject = 1'b1;
         end else if (!pend_valid || apply) begin
            accept = 1'b1;
         end
      end
   end

   assign hi = HW'(calc_hi(32'(d_eff)));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Active divisor and pending slot; apply frees the slot on the same edge it may refill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_reg      <= WIDTH'(DIV_DEFAULT);
         pend_val   <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (apply) begin
            d_reg <= pend_val;
         end
         if (accept) begin
            pend_val   <= div_val;
            pend_valid <= 1'b1;
         end else if (apply) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // Handshake response pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_ack <= 1'b0;
         div_err <= 1'b0;
      end else begin
         div_ack <= accept;
         div_err <= reject;
      end
   end

   // Registered divided outputs; forced idle whenever the edge sees en=0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_out   <= 1'b0;
         clk_out_n <= 1'b1;
         tick      <= 1'b0;
      end else if (en) begin
         clk_out   <= ({1'b0, phase_next} < hi);
         clk_out_n <= !({1'b0, phase_next} < hi);
         tick      <= wrap;
      end else begin
         clk_out   <= 1'b0;
         clk_out_n <= 1'b1;
         tick      <= 1'b0;
      end
   end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Parametrised programmable clock-enable divider, the next generation of the T-flip-flop divide-by-2 stage. It generates a divided square wave (true and complement) and a one-cycle period tick from the system clock. The divisor D is runtime-loadable through a valid/ack handshake and is applied glitch-free at period boundaries. The block is used wherever slower strobes or divided clocks-as-data are needed. All logic runs on posedge clk only.

Parameters:
WIDTH, 8, width of the divisor and phase counter.
DIV_DEFAULT, 2, divisor after reset; must be in the range 2..2^WIDTH-1.

Ports:
clk  input  1  system clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  run enable, sampled each edge.
div_val  input  WIDTH  requested divisor; held stable while div_load is high.
div_load  input  1  divisor load request; held until div_ack or div_err.
div_ack  output  1  one-cycle pulse; div_val was captured into pending.
div_err  output  1  one-cycle pulse; div_val was below 2 and rejected.
clk_out  output  1  divided output, registered.
clk_out_n  output  1  complement of clk_out, registered.
tick  output  1  one-cycle pulse coincident with each clk_out rising phase.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - clk_out=0, clk_out_n=1, tick=0, div_ack=0, div_err=0.
  - phase=0, state=IDLE, D=DIV_DEFAULT, pending empty.
- States: IDLE and RUN.
  - IDLE to RUN on an edge with en=1.
  - RUN to IDLE on an edge with en=0.
- Phase sequencing:
  - HI = ceil(D/2).
  - On an edge with en=1: phase_next = 0 if leaving IDLE or phase==D-1; otherwise phase+1.
  - clk_out <= (phase_next < HI); clk_out_n <= ~(phase_next < HI); tick <= (phase_next==0).
  - Latency: en high at edge k gives clk_out=1 and tick=1 immediately after edge k.
  - Period is exactly D cycles. The high time is HI cycles and the low time is D-HI cycles (odd D gives the longer high).
  - With D=2 the output toggles every cycle, matching a T flip-flop with t=1.
- en=0 on an edge:
  - clk_out=0, clk_out_n=1, tick=0, phase=0.
  - The divisor is held; no partial period is resumed.
- Load handshake, evaluated each edge with div_load=1:
  - div_val<2: div_err pulses next cycle; D and pending are unchanged.
  - div_val>=2 and pending empty: capture into pending; div_ack pulses next cycle.
  - Pending full: no ack. The requester keeps div_load high (stall) until pending drains.
- Applying the pending divisor:
  - In RUN, pending is applied on the edge where phase_next==0. That edge's clk_out and tick already use the new D.
  - In IDLE, pending is applied on the next edge.
  - The pending slot is freed on the same edge, so a held load can be acked one cycle later.
- Simultaneous wrap and capture on the same edge: the old pending is applied and the new value is captured into pending. No request is lost or duplicated.
- div_ack and div_err are never asserted together and are never asserted on consecutive cycles for one request.
- Reset mid-operation: all state returns to reset values immediately; the pending divisor is discarded and any in-flight load is not acked.
- Arithmetic: phase and D are WIDTH bits and unsigned; HI is computed as (D+1)>>1 at WIDTH+1 bits.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum {IDLE, RUN};
  - localparam DIV_MIN=2;
  - a function computing HI from D.
- Sub-module clk_div_phase: WIDTH-bit wrapping phase counter with restart input, producing phase_next and a wrap flag.
- Handshake, pending register and output registers live in the top level.

Test Plan:
- Reset with rst=0 held for 3 cycles -> clk_out=0, clk_out_n=1, tick=0, div_ack=0, div_err=0. After release with en=0, outputs stay idle.
- Default D=2, en=1 from edge 0 -> clk_out 1,0,1,0,…; clk_out_n inverse; tick on edges 0,2,4.
- Load 5 while running at D=2 -> div_ack one cycle after request. New divisor takes effect at the next wrap, then clk_out repeats 1,1,1,0,0 with tick every 5 cycles.
- div_val=1 with div_load=1 -> div_err single pulse, no div_ack; period remains unchanged.
- Load 6 then immediately load 3 (pending full) -> second request stalls with no ack until 6 is applied at a wrap. The 3 is acked the next cycle and applied at the following wrap.
- en=0 at phase 2 of D=5 -> outputs idle next cycle. en=1 again -> fresh period starting clk_out=1, tick=1. Separately, rst=0 mid-period -> immediate reset values and D back to DIV_DEFAULT.
